// File: rtl/sim_end_ctrl.sv
// Run-termination responder: counts RUN cycles and accepted events, raises a
// finish request on stop / cycle limit / idle timeout. Optional heartbeat: SIM_END_CTRL_HEARTBEAT_EN.
module sim_end_ctrl #(
    parameter int CNT_W        = 32,
    parameter int MAX_CYCLES   = 1000,
    parameter int IDLE_TIMEOUT = 64,
    parameter int HB_PERIOD    = 256
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             event_valid_i,
    output logic             event_ready_o,
    input  logic             stop_req_i,
    output logic             finish_req_o,
    input  logic             finish_ack_i,
    output logic [1:0]       finish_code_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] event_cnt_o,
    output logic             busy_o,
    output logic             heartbeat_o
);

    // state   | meaning
    // IDLE    | waiting for start_i
    // RUN     | counting cycles/events, evaluating termination
    // REQ     | finish_req_o high, waiting for finish_ack_i
    // DONE    | run over, outputs frozen until reset
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_REQ, ST_DONE} state_t;

    localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);
    localparam bit               IDLE_EN   = (IDLE_TIMEOUT != 0);

    if (MAX_CYCLES < 1) begin : g_bad_max
        $error("MAX_CYCLES must be >= 1");
    end
    if (HB_PERIOD < 1) begin : g_bad_hb
        $error("HB_PERIOD must be >= 1");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] evt_q, evt_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic [1:0]       code_q, code_d;
    logic [1:0]       term_code;
    logic             accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign accept = (state_q == ST_RUN) && event_valid_i;

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        evt_d     = evt_q;
        idle_d    = idle_q;
        code_d    = code_q;
        term_code = 2'd0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    cyc_d   = '0;
                    evt_d   = '0;
                    idle_d  = '0;
                end
            end
            ST_RUN: begin
                // Termination uses pre-update counter values.
                if (stop_req_i)
                    term_code = 2'd1;
                else if (cyc_q == CYC_LAST)
                    term_code = 2'd2;
                else if (IDLE_EN && (idle_q == IDLE_LAST) && !accept)
                    term_code = 2'd3;
                cyc_d  = sat_inc(cyc_q);
                evt_d  = accept ? sat_inc(evt_q) : evt_q;
                idle_d = accept ? '0 : sat_inc(idle_q);
                if (term_code != 2'd0) begin
                    state_d = ST_REQ;
                    code_d  = term_code;
                end
            end
            ST_REQ: begin
                if (finish_ack_i)
                    state_d = ST_DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            evt_q   <= '0;
            idle_q  <= '0;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            evt_q   <= evt_d;
            idle_q  <= idle_d;
            code_q  <= code_d;
        end
    end

    assign event_ready_o = (state_q == ST_RUN);
    assign finish_req_o  = (state_q == ST_REQ);
    assign busy_o        = (state_q == ST_RUN) || (state_q == ST_REQ);
    assign finish_code_o = code_q;
    assign cycle_cnt_o   = cyc_q;
    assign event_cnt_o   = evt_q;

`ifdef SIM_END_CTRL_HEARTBEAT_EN
    localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(HB_PERIOD - 1);

    logic [CNT_W-1:0] hb_cnt_q, hb_cnt_d;
    logic             hb_q, hb_d;

    always_comb begin
        hb_cnt_d = hb_cnt_q;
        hb_d     = 1'b0;
        if (state_q == ST_IDLE && start_i) begin
            hb_cnt_d = '0;
        end else if (state_q == ST_RUN) begin
            if (hb_cnt_q == HB_LAST) begin
                hb_cnt_d = '0;
                // No pulse once the run has ended on this cycle.
                hb_d     = (term_code == 2'd0);
            end else begin
                hb_cnt_d = hb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else begin
            hb_cnt_q <= hb_cnt_d;
            hb_q     <= hb_d;
        end
    end

    assign heartbeat_o = hb_q;
`else
    assign heartbeat_o = 1'b0;
`endif

endmodule

// File: tb/tb_sim_end_ctrl.sv
// Bench for sim_end_ctrl: directed scenarios then random stimulus, all checked
// against a run-level reference model. Heartbeat expectations follow SIM_END_CTRL_HEARTBEAT_EN.
module tb_sim_end_ctrl;

    localparam int W    = 32;
    localparam int MAXC = 10;
    localparam int IT   = 4;
    localparam int HB   = 4;
`ifdef SIM_END_CTRL_HEARTBEAT_EN
    localparam bit HB_EN = 1'b1;
`else
    localparam bit HB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n, start, valid, stop, ack;
    logic         ready, freq, busy, hb;
    logic [1:0]   code;
    logic [W-1:0] cyc, evt;

    always #5 clk = ~clk;

    sim_end_ctrl #(.CNT_W(W), .MAX_CYCLES(MAXC), .IDLE_TIMEOUT(IT), .HB_PERIOD(HB)) dut (
        .clk_i(clk), .reset_n(rst_n), .start_i(start), .event_valid_i(valid),
        .event_ready_o(ready), .stop_req_i(stop), .finish_req_o(freq),
        .finish_ack_i(ack), .finish_code_o(code), .cycle_cnt_o(cyc),
        .event_cnt_o(evt), .busy_o(busy), .heartbeat_o(hb)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int hb_seen;

    // Reference model: phase of the run plus tallies of what happened in it.
    typedef enum int {P_IDLE, P_RUN, P_REQ, P_DONE} phase_t;
    phase_t  m_ph   = P_IDLE;
    longint  m_cyc  = 0;
    longint  m_evt  = 0;
    longint  m_last = 0;   // RUN-cycle index of the most recent accepted event
    int      m_code = 0;
    bit      m_hb   = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int c;
        m_hb = 1'b0;
        if (!rst_n) begin
            m_ph = P_IDLE; m_cyc = 0; m_evt = 0; m_last = 0; m_code = 0;
            return;
        end
        case (m_ph)
            P_IDLE: if (start) begin
                m_ph = P_RUN; m_cyc = 0; m_evt = 0; m_last = 0;
            end
            P_RUN: begin
                // Cycles since the last accepted event (or RUN entry), before this one.
                c = 0;
                if (stop)                                           c = 1;
                else if (m_cyc + 1 == MAXC)                         c = 2;
                else if (IT != 0 && !valid && m_cyc - m_last + 1 == IT) c = 3;
                m_cyc = m_cyc + 1;
                if (valid) begin
                    m_evt  = m_evt + 1;
                    m_last = m_cyc;
                end
                if (c != 0) begin
                    m_ph = P_REQ; m_code = c;
                end else begin
                    m_hb = HB_EN && (m_cyc % HB == 0);
                end
            end
            P_REQ: if (ack) m_ph = P_DONE;
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("ready", ready, m_ph == P_RUN);
        check("finish_req", freq, m_ph == P_REQ);
        check("busy", busy, m_ph == P_RUN || m_ph == P_REQ);
        check("code", code, m_code);
        check("cycle_cnt", cyc, m_cyc);
        check("event_cnt", evt, m_evt);
        check("heartbeat", hb, m_hb);
        if (hb) hb_seen++;
    endtask

    task automatic drive(input logic r, input logic s, input logic v, input logic st, input logic a);
        rst_n = r; start = s; valid = v; stop = st; ack = a;
    endtask

    initial begin
        int vbias;
        drive(0, 0, 0, 0, 0);

        // Reset then quiet IDLE
        repeat (3) tick();
        drive(1, 0, 0, 0, 0);
        repeat (20) tick();
        check("idle_ready", ready, 1'b0);

        // Cycle limit with an event every cycle
        drive(1, 1, 0, 0, 0); tick();
        hb_seen = 0;
        drive(1, 0, 1, 0, 0);
        repeat (MAXC) tick();
        check("lim_req", freq, 1'b1);
        check("lim_code", code, 2);
        check("lim_cyc", cyc, MAXC);
        check("lim_evt", evt, MAXC);
        check("hb_pulses", hb_seen, HB_EN ? 2 : 0);
        drive(1, 0, 0, 0, 0);
        repeat (3) tick();
        check("lim_req_held", freq, 1'b1);
        drive(1, 0, 0, 0, 1); tick();
        check("ack_req", freq, 1'b0);
        check("ack_busy", busy, 1'b0);
        drive(1, 1, 0, 0, 0); repeat (3) tick();
        check("done_ignores_start", busy, 1'b0);

        // Idle timeout: events on RUN cycles 1-2 only
        drive(0, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 0); tick();
        drive(1, 0, 1, 0, 0); repeat (2) tick();
        drive(1, 0, 0, 0, 0); repeat (4) tick();
        check("to_code", code, 3);
        check("to_cyc", cyc, 6);
        check("to_evt", evt, 2);

        // Stop coincides with the cycle limit
        drive(0, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 0); tick();
        drive(1, 0, 1, 0, 0); repeat (MAXC - 1) tick();
        drive(1, 0, 1, 1, 0); tick();
        check("prio_code", code, 1);
        check("prio_cyc", cyc, MAXC);

        // Reset while a request is pending, then a fresh run
        drive(0, 0, 0, 0, 0); tick();
        check("mid_req_req", freq, 1'b0);
        check("mid_req_cyc", cyc, 0);
        drive(1, 1, 0, 0, 0); tick();
        drive(1, 0, 1, 0, 0); repeat (MAXC) tick();
        check("rerun_code", code, 2);

        // Random traffic
        vbias = 5;
        for (int i = 0; i < 1500; i++) begin
            if (i % 50 == 0) vbias = $urandom_range(10);
            drive(($urandom_range(99) != 0), ($urandom_range(3) == 0),
                  ($urandom_range(9) < vbias), ($urandom_range(39) == 0),
                  ($urandom_range(2) == 0));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
